// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for seven-segment display blocks
package seg_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {BLANK, SHOW} scan_state_t;
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low {g,f,e,d,c,b,a} decoder
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_TABLE[i_hex];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner with frame-boundary buffered loads
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic [DIGITS-1:0]     load_dp,
  input  logic [DIGITS-1:0]     load_blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);
  localparam int CW = $clog2(REFRESH_DIV + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  scan_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [4*DIGITS-1:0] r_act_data, r_pend_data, w_act_data_nxt;
  logic [DIGITS-1:0] r_act_dp, r_act_blank, r_pend_dp, r_pend_blank;
  logic [DIGITS-1:0] w_act_dp_nxt, w_act_blank_nxt, w_an_nxt;
  logic r_act_valid, r_pend_full, r_load_ready, w_act_valid_nxt, w_pend_full_nxt;
  logic [6:0] r_seg, w_seg_nxt, w_dec;
  logic r_dp, r_frame_done, w_dp_nxt, w_fd_nxt, w_on;
  logic w_wrap, w_accept, w_commit;
  logic [3:0] w_nib;

  // Slot state, slot counter and digit index register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next slot state: blank lead-in, then show until the slot ends and the index advances
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    if (r_state == BLANK) begin
      if (r_cnt == CW'(BLANK_CYCLES - 1)) w_state_nxt = SHOW;
    end else if (r_cnt == CW'(REFRESH_DIV - 1)) begin
      w_state_nxt = BLANK;
      w_cnt_nxt   = '0;
      w_idx_nxt   = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end
  end

  assign w_wrap   = (r_state == SHOW) && (r_cnt == CW'(REFRESH_DIV - 1)) && (r_idx == IW'(DIGITS - 1));
  assign w_accept = load_valid && !r_pend_full;
  assign w_commit = w_wrap && r_pend_full;

  // Active frame as it will be after this edge; a commit only ever happens on the wrap
  always_comb begin
    w_act_data_nxt  = w_commit ? r_pend_data  : r_act_data;
    w_act_dp_nxt    = w_commit ? r_pend_dp    : r_act_dp;
    w_act_blank_nxt = w_commit ? r_pend_blank : r_act_blank;
    w_act_valid_nxt = r_act_valid || w_commit;
    w_pend_full_nxt = w_accept || (r_pend_full && !w_commit);
  end

  // Pending and active frame buffers plus the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_full  <= 1'b0;
      r_load_ready <= 1'b1;
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
      r_act_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend_data  <= load_data;
        r_pend_dp    <= load_dp;
        r_pend_blank <= load_blank;
      end
      r_pend_full  <= w_pend_full_nxt;
      r_load_ready <= !w_pend_full_nxt;
      r_act_data   <= w_act_data_nxt;
      r_act_dp     <= w_act_dp_nxt;
      r_act_blank  <= w_act_blank_nxt;
      r_act_valid  <= w_act_valid_nxt;
    end
  end

  assign w_nib = w_act_data_nxt[{w_idx_nxt, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .i_hex (w_nib),
    .o_seg (w_dec)
  );

  // Output values for the upcoming cycle; segments are blanked whenever the anode is off
  always_comb begin
    w_on      = (w_state_nxt == SHOW) && w_act_valid_nxt && !w_act_blank_nxt[w_idx_nxt];
    w_an_nxt  = w_on ? ~(DIGITS'(1) << w_idx_nxt) : AN_OFF[DIGITS-1:0];
    w_seg_nxt = w_on ? w_dec : SEG_OFF;
    w_dp_nxt  = w_on ? !w_act_dp_nxt[w_idx_nxt] : 1'b1;
    w_fd_nxt  = (w_idx_nxt == IW'(DIGITS - 1)) && (w_cnt_nxt == CW'(REFRESH_DIV - 1));
  end

  // Registered display outputs aligned with the slot state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      an           <= AN_OFF[DIGITS-1:0];
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      an           <= w_an_nxt;
      r_frame_done <= w_fd_nxt;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;
  assign load_ready = r_load_ready;
endmodule
